// File: rtl/pkt_pkg.sv
// -----------------------------------------------------------------------------
// pkt_pkg
// Shared types for the packet-copy arbitration path.
//  arb_state_t : arbiter FSM encoding, also used when decoding state_out
//                (IDLE=0, START=1, WAIT=2, DONE=3).
//  N_REQ_DEF / TIMEOUT_DEF / TMO_W_DEF : default build parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package pkt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 1024;
    localparam int TMO_W_DEF   = 16;

endpackage

// File: rtl/pkt_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Returns the first set request bit at or
// after the pointer position, wrapping past N_REQ-1 back to 0. No state.
// Ports:
//  i_req   in  N_REQ          request vector
//  i_ptr   in  $clog2(N_REQ)  highest-priority channel index (must be < N_REQ)
//  o_valid out 1              at least one request is set
//  o_idx   out $clog2(N_REQ)  index of the winning channel (0 when !o_valid)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic                     o_valid,
    output logic [$clog2(N_REQ)-1:0] o_idx
);

    localparam int CH_W = $clog2(N_REQ);

    // w_pos[k] is the channel sitting k places after the pointer; w_cand[k]
    // is its request bit, so w_cand is the request vector rotated to start
    // at the pointer.
    logic [CH_W-1:0]  w_pos [N_REQ];
    logic [N_REQ-1:0] w_cand;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [CH_W:0] w_sum;
        assign w_sum       = {1'b0, i_ptr} + (CH_W+1)'(gi);
        assign w_pos[gi]   = (w_sum >= (CH_W+1)'(N_REQ))
                             ? CH_W'(w_sum - (CH_W+1)'(N_REQ))
                             : CH_W'(w_sum);
        assign w_cand[gi]  = i_req[w_pos[gi]];
    end

    // Scan from the far end so the candidate closest to the pointer wins.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                o_idx = w_pos[k];
            end
        end
    end

endmodule

// File: rtl/pkt_arb.sv
// -----------------------------------------------------------------------------
// pkt_arb
// Round-robin scheduler sharing one packet-copy controller between N_REQ
// capture channels. Grants one channel, pulses xfer_start, then waits for
// xfer_done or a watchdog timeout, and reports done/err for that channel.
// Ports:
//  clk         in   1      clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  req         in   N_REQ  level request per channel (sampled in IDLE only)
//  gnt         out  N_REQ  one-hot grant, high START..DONE
//  done        out  N_REQ  1-cycle pulse, granted transfer finished
//  err         out  N_REQ  1-cycle pulse, granted transfer timed out
//  xfer_start  out  1      1-cycle start pulse to packet controller
//  xfer_chan   out  CH_W   granted channel index, stable START..DONE
//  xfer_done   in   1      completion from packet controller (WAIT only)
//  xfer_abort  out  1      1-cycle abort pulse on timeout
//  busy        out  1      high whenever the FSM is not IDLE
//  state_out   out  2      FSM state encoding (arb_state_t)
// -----------------------------------------------------------------------------
module pkt_arb
    import pkt_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TMO_W   = TMO_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         err,
    output logic                     xfer_start,
    output logic [$clog2(N_REQ)-1:0] xfer_chan,
    input  logic                     xfer_done,
    output logic                     xfer_abort,
    output logic                     busy,
    output logic [1:0]               state_out
);

    localparam int CH_W = $clog2(N_REQ);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [N_REQ-1:0] r_gnt;
    logic [CH_W-1:0]  r_chan;
    logic [CH_W-1:0]  r_ptr;
    logic [TMO_W-1:0] r_wd;
    logic             r_ok;

    logic             w_valid;
    logic [CH_W-1:0]  w_idx;
    logic             w_tmo;
    logic [CH_W-1:0]  w_ptr_next;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // Last WAIT cycle: the watchdog has counted TIMEOUT WAIT cycles.
    assign w_tmo      = (r_wd == TMO_W'(TIMEOUT - 1));
    assign w_ptr_next = (r_chan == CH_W'(N_REQ - 1)) ? '0 : r_chan + 1'b1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_state_next = START;
            START:   w_state_next = WAIT;
            WAIT:    if (xfer_done || w_tmo) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_chan  <= '0;
            r_ptr   <= '0;
            r_wd    <= '0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt  <= N_REQ'(1) << w_idx;
                        r_chan <= w_idx;
                    end
                end
                START: begin
                    r_wd <= '0;
                end
                WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    // Captured every WAIT cycle; only the value on the exit
                    // cycle matters, so done beats a simultaneous timeout.
                    r_ok <= xfer_done;
                end
                DONE: begin
                    r_gnt <= '0;
                    r_ptr <= w_ptr_next;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    // Every output is a register or a decode of registers; r_gnt still holds
    // the one-hot channel during DONE, so it doubles as the done/err mask.
    assign gnt        = r_gnt;
    assign xfer_chan  = r_chan;
    assign xfer_start = (r_state == START);
    assign busy       = (r_state != IDLE);
    assign state_out  = r_state;
    assign done       = ((r_state == DONE) &&  r_ok) ? r_gnt : '0;
    assign err        = ((r_state == DONE) && !r_ok) ? r_gnt : '0;
    assign xfer_abort = (r_state == DONE) && !r_ok;

endmodule

// File: tb/tb_pkt_arb.sv
// -----------------------------------------------------------------------------
// tb_pkt_arb
// Self-checking bench for pkt_arb (N_REQ=4, TIMEOUT=16). Each test task pushes
// the expected grant channel and outcome into a queue as it drives requests,
// then pops and compares once the transfer reaches DONE.
// -----------------------------------------------------------------------------
module tb_pkt_arb;

    typedef struct {
        int chan;
        bit ok;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [3:0] err;
    logic       xfer_start;
    logic [1:0] xfer_chan;
    logic       xfer_done;
    logic       xfer_abort;
    logic       busy;
    logic [1:0] state_out;

    int   npass = 0;
    int   ntot  = 0;
    exp_t exp_q[$];

    pkt_arb #(
        .N_REQ   (4),
        .TIMEOUT (16),
        .TMO_W   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .xfer_start (xfer_start),
        .xfer_chan  (xfer_chan),
        .xfer_done  (xfer_done),
        .xfer_abort (xfer_abort),
        .busy       (busy),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        xfer_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one transfer: wait (bounded) for xfer_start, optionally drop req,
    // assert xfer_done on the dly-th WAIT cycle (never if dly<0), and capture
    // the outputs in the DONE cycle.
    task automatic run_xfer(input int dly, input bit drop_req,
                            output bit st_ok, output int n_st, output int ch,
                            output logic [3:0] g, output bit en_ok,
                            output int nwait, output logic [3:0] dv,
                            output logic [3:0] ev, output logic ab);
        st_ok = 1'b0; en_ok = 1'b0; n_st = 0; ch = -1; g = '0;
        nwait = 0; dv = '0; ev = '0; ab = 1'b0;
        while (n_st < 20 && xfer_start !== 1'b1) begin
            @(negedge clk);
            n_st++;
        end
        if (xfer_start !== 1'b1) return;
        st_ok = 1'b1;
        ch    = int'(xfer_chan);
        g     = gnt;
        if (drop_req) req = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            xfer_done = 1'b0;
            if (state_out == 2'd3) begin
                en_ok = 1'b1;
                dv    = done;
                ev    = err;
                ab    = xfer_abort;
                break;
            end
            if (state_out == 2'd2) begin
                nwait++;
                if (nwait == dly) xfer_done = 1'b1;
            end
        end
        xfer_done = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req       = 4'hF;
        xfer_done = 1'b1;
        repeat (3) @(negedge clk);
        ntot++;
        if ({gnt, done, err, xfer_start, xfer_abort, busy, xfer_chan, state_out} !== 17'd0)
            $display("FAIL reset_outputs: gnt=%b done=%b err=%b start=%b abort=%b busy=%b chan=%0d state=%0d, want all 0",
                     gnt, done, err, xfer_start, xfer_abort, busy, xfer_chan, state_out);
        else npass++;
        reset     = 1'b0;
        req       = '0;
        xfer_done = 1'b0;
        @(negedge clk);
        ntot++;
        if (state_out !== 2'd0 || busy !== 1'b0)
            $display("FAIL reset_idle: state=%0d busy=%b, want 0 0", state_out, busy);
        else npass++;
    endtask

    task automatic test_single();
        bit st_ok, en_ok; int n_st, ch, nwait; logic [3:0] g, dv, ev; logic ab;
        exp_t e; logic [12:0] want;
        do_reset();
        req = 4'b0001;
        exp_q.push_back('{chan: 0, ok: 1'b1});
        run_xfer(5, 1'b0, st_ok, n_st, ch, g, en_ok, nwait, dv, ev, ab);
        req = '0;
        ntot++;
        if (!st_ok || n_st != 1)
            $display("FAIL single_latency: start seen=%0b after %0d cycles, want 1 after 1", st_ok, n_st);
        else npass++;
        e    = exp_q.pop_front();
        want = {4'(1 << e.chan), e.ok ? 4'(1 << e.chan) : 4'b0, e.ok ? 4'b0 : 4'(1 << e.chan), ~e.ok};
        ntot++;
        if (!en_ok || ch != e.chan || {g, dv, ev, ab} !== want)
            $display("FAIL single_xfer: ch=%0d gnt/done/err/abort=%h end=%0b, want ch=%0d %h",
                     ch, {g, dv, ev, ab}, en_ok, e.chan, want);
        else npass++;
        @(negedge clk);
        ntot++;
        if (state_out !== 2'd0 || done !== 4'b0 || gnt !== 4'b0)
            $display("FAIL single_return: state=%0d done=%b gnt=%b, want 0 0000 0000", state_out, done, gnt);
        else npass++;
    endtask

    task automatic test_round_robin();
        bit st_ok, en_ok; int n_st, ch, nwait; logic [3:0] g, dv, ev; logic ab;
        exp_t e; logic [12:0] want;
        do_reset();
        req = 4'hF;
        exp_q.push_back('{chan: 0, ok: 1'b1});
        exp_q.push_back('{chan: 1, ok: 1'b1});
        exp_q.push_back('{chan: 2, ok: 1'b1});
        exp_q.push_back('{chan: 3, ok: 1'b1});
        exp_q.push_back('{chan: 0, ok: 1'b1});
        for (int i = 0; i < 5; i++) begin
            run_xfer(3, 1'b0, st_ok, n_st, ch, g, en_ok, nwait, dv, ev, ab);
            e    = exp_q.pop_front();
            want = {4'(1 << e.chan), e.ok ? 4'(1 << e.chan) : 4'b0, e.ok ? 4'b0 : 4'(1 << e.chan), ~e.ok};
            ntot++;
            if (!st_ok || !en_ok || ch != e.chan || {g, dv, ev, ab} !== want)
                $display("FAIL rr_grant%0d: ch=%0d gnt/done/err/abort=%h start=%0b end=%0b, want ch=%0d %h",
                         i, ch, {g, dv, ev, ab}, st_ok, en_ok, e.chan, want);
            else npass++;
            @(negedge clk);
            ntot++;
            if (done !== 4'b0 || err !== 4'b0 || state_out !== 2'd0)
                $display("FAIL rr_pulse%0d: done=%b err=%b state=%0d, want 0000 0000 0", i, done, err, state_out);
            else npass++;
        end
        req = '0;
    endtask

    task automatic test_timeout();
        bit st_ok, en_ok; int n_st, ch, nwait; logic [3:0] g, dv, ev; logic ab;
        exp_t e; logic [12:0] want;
        do_reset();
        req = 4'b0011;
        exp_q.push_back('{chan: 0, ok: 1'b0});
        exp_q.push_back('{chan: 1, ok: 1'b1});
        run_xfer(-1, 1'b0, st_ok, n_st, ch, g, en_ok, nwait, dv, ev, ab);
        ntot++;
        if (nwait != 16)
            $display("FAIL tmo_wait_cycles: %0d WAIT cycles, want 16", nwait);
        else npass++;
        e    = exp_q.pop_front();
        want = {4'(1 << e.chan), e.ok ? 4'(1 << e.chan) : 4'b0, e.ok ? 4'b0 : 4'(1 << e.chan), ~e.ok};
        ntot++;
        if (!st_ok || !en_ok || ch != e.chan || {g, dv, ev, ab} !== want)
            $display("FAIL tmo_abort: ch=%0d gnt/done/err/abort=%h end=%0b, want ch=%0d %h",
                     ch, {g, dv, ev, ab}, en_ok, e.chan, want);
        else npass++;
        run_xfer(2, 1'b0, st_ok, n_st, ch, g, en_ok, nwait, dv, ev, ab);
        req  = '0;
        e    = exp_q.pop_front();
        want = {4'(1 << e.chan), e.ok ? 4'(1 << e.chan) : 4'b0, e.ok ? 4'b0 : 4'(1 << e.chan), ~e.ok};
        ntot++;
        if (!st_ok || !en_ok || ch != e.chan || {g, dv, ev, ab} !== want)
            $display("FAIL tmo_next: ch=%0d gnt/done/err/abort=%h end=%0b, want ch=%0d %h",
                     ch, {g, dv, ev, ab}, en_ok, e.chan, want);
        else npass++;
    endtask

    task automatic test_done_on_timeout();
        bit st_ok, en_ok; int n_st, ch, nwait; logic [3:0] g, dv, ev; logic ab;
        exp_t e; logic [12:0] want;
        do_reset();
        req = 4'b0001;
        exp_q.push_back('{chan: 0, ok: 1'b1});
        run_xfer(16, 1'b0, st_ok, n_st, ch, g, en_ok, nwait, dv, ev, ab);
        req  = '0;
        e    = exp_q.pop_front();
        want = {4'(1 << e.chan), e.ok ? 4'(1 << e.chan) : 4'b0, e.ok ? 4'b0 : 4'(1 << e.chan), ~e.ok};
        ntot++;
        if (!st_ok || !en_ok || nwait != 16 || ch != e.chan || {g, dv, ev, ab} !== want)
            $display("FAIL done_vs_tmo: ch=%0d wait=%0d gnt/done/err/abort=%h, want ch=%0d wait=16 %h",
                     ch, nwait, {g, dv, ev, ab}, e.chan, want);
        else npass++;
    endtask

    task automatic test_reset_in_wait();
        bit st_ok, en_ok; int n_st, ch, nwait; logic [3:0] g, dv, ev; logic ab;
        exp_t e; logic [12:0] want;
        do_reset();
        // Move the pointer off zero first so a pointer not cleared by reset shows.
        req = 4'b0010;
        exp_q.push_back('{chan: 1, ok: 1'b1});
        run_xfer(2, 1'b0, st_ok, n_st, ch, g, en_ok, nwait, dv, ev, ab);
        e    = exp_q.pop_front();
        want = {4'(1 << e.chan), e.ok ? 4'(1 << e.chan) : 4'b0, e.ok ? 4'b0 : 4'(1 << e.chan), ~e.ok};
        ntot++;
        if (!st_ok || !en_ok || ch != e.chan || {g, dv, ev, ab} !== want)
            $display("FAIL rstw_pre: ch=%0d gnt/done/err/abort=%h, want ch=%0d %h", ch, {g, dv, ev, ab}, e.chan, want);
        else npass++;
        req = 4'b0100;
        repeat (5) @(negedge clk);
        ntot++;
        if (state_out !== 2'd2)
            $display("FAIL rstw_in_wait: state=%0d, want 2", state_out);
        else npass++;
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        ntot++;
        if ({gnt, done, err, xfer_start, xfer_abort, busy, xfer_chan, state_out} !== 17'd0)
            $display("FAIL rstw_outputs: gnt=%b done=%b err=%b start=%b abort=%b busy=%b chan=%0d state=%0d, want all 0",
                     gnt, done, err, xfer_start, xfer_abort, busy, xfer_chan, state_out);
        else npass++;
        reset = 1'b0;
        req   = 4'b1001;
        exp_q.push_back('{chan: 0, ok: 1'b1});
        exp_q.push_back('{chan: 3, ok: 1'b1});
        for (int i = 0; i < 2; i++) begin
            run_xfer(2, 1'b0, st_ok, n_st, ch, g, en_ok, nwait, dv, ev, ab);
            e    = exp_q.pop_front();
            want = {4'(1 << e.chan), e.ok ? 4'(1 << e.chan) : 4'b0, e.ok ? 4'b0 : 4'(1 << e.chan), ~e.ok};
            ntot++;
            if (!st_ok || !en_ok || ch != e.chan || {g, dv, ev, ab} !== want)
                $display("FAIL rstw_post%0d: ch=%0d gnt/done/err/abort=%h end=%0b, want ch=%0d %h",
                         i, ch, {g, dv, ev, ab}, en_ok, e.chan, want);
            else npass++;
        end
        req = '0;
    endtask

    task automatic test_req_drop_spurious();
        bit st_ok, en_ok; int n_st, ch, nwait; logic [3:0] g, dv, ev; logic ab;
        exp_t e; logic [12:0] want;
        do_reset();
        req = 4'b0100;
        exp_q.push_back('{chan: 2, ok: 1'b1});
        run_xfer(2, 1'b1, st_ok, n_st, ch, g, en_ok, nwait, dv, ev, ab);
        e    = exp_q.pop_front();
        want = {4'(1 << e.chan), e.ok ? 4'(1 << e.chan) : 4'b0, e.ok ? 4'b0 : 4'(1 << e.chan), ~e.ok};
        ntot++;
        if (!st_ok || !en_ok || ch != e.chan || {g, dv, ev, ab} !== want)
            $display("FAIL drop_xfer: ch=%0d gnt/done/err/abort=%h end=%0b, want ch=%0d %h",
                     ch, {g, dv, ev, ab}, en_ok, e.chan, want);
        else npass++;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            xfer_done = 1'b1;
            @(negedge clk);
            ntot++;
            if ({state_out, gnt, done, err, xfer_start, xfer_abort, busy} !== 17'd0)
                $display("FAIL spurious_done%0d: state=%0d gnt=%b done=%b err=%b start=%b abort=%b busy=%b, want all 0",
                         i, state_out, gnt, done, err, xfer_start, xfer_abort, busy);
            else npass++;
        end
        xfer_done = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        xfer_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_done_on_timeout();
        test_reset_in_wait();
        test_req_drop_spurious();
        ntot++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        else npass++;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
